// File: rtl/sync_fifo_pkg.sv
// Shared constants, helper function and status record for the parametrised sync FIFO.
package sync_fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_DEPTH      = 16;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

   // Address width that never collapses to zero bits for tiny depths.
   function automatic int clog2_safe(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, asynchronous read port.
module fifo_mem_2p
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int ADDR_W     = clog2_safe(DEFAULT_DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through; default is a 1-cycle registered read.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int DEPTH         = DEFAULT_DEPTH,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic                   rd_en,
   output logic [DATA_WIDTH-1:0]  data_out,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int PTR_W = clog2_safe(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
   localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "sync_fifo_param: DEPTH must be a power of two and at least 4");
   end

   if (AEMPTY_THRESH <= 0 || AEMPTY_THRESH >= AFULL_THRESH || AFULL_THRESH > DEPTH) begin : g_bad_thresh
      $fatal(1, "sync_fifo_param: thresholds must satisfy 0 < AEMPTY < AFULL <= DEPTH");
   end

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  wr_acc;
   logic                  rd_acc;

   // Full-with-both favours the read, empty-with-both favours the write: no pass-through.
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   assign full         = (count == FULL_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AFULL_C);
   assign almost_empty = (count <= AEMPTY_C);

   fifo_mem_2p #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (PTR_W)
   ) u_mem (
      .clk     (clk),
      .we      (wr_acc && rst_n),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign data_out = empty ? '0 : rd_data;
`else
   logic [DATA_WIDTH-1:0] data_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= '0;
      end else if (rd_acc) begin
         data_q <= rd_data;
      end
   end

   assign data_out = data_q;
`endif

endmodule
